// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path: widths, %g0 address, port ids.
package rf_pkg;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned G0_ADDR = 0;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/rf_write_slot.sv
// One-entry holding register for a writeback request; load wins over clear.
module rf_write_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_rd,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rd    <= load_rd;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbitration of two writeback slots onto the single register-file write port.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = rf_pkg::DATA_W,
  parameter int unsigned ADDR_W = rf_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] C,
  output logic              RF,
  output logic [DATA_W-1:0] PW,
  output logic              busy
);

  import rf_pkg::*;

  logic              a_full, b_full;
  logic [ADDR_W-1:0] a_slot_rd, b_slot_rd;
  logic [DATA_W-1:0] a_slot_data, b_slot_data;
  logic              grant_a_c, grant_b_c, grant_c;
  logic              a_load_c, b_load_c;
  logic [ADDR_W-1:0] sel_rd_c;
  logic [DATA_W-1:0] sel_data_c;
  port_e             last;

  rf_write_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .clk       (clk),
    .reset     (reset),
    .load      (a_load_c),
    .clear     (grant_a_c),
    .load_rd   (a_rd),
    .load_data (a_data),
    .valid     (a_full),
    .rd        (a_slot_rd),
    .data      (a_slot_data)
  );

  rf_write_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .clk       (clk),
    .reset     (reset),
    .load      (b_load_c),
    .clear     (grant_b_c),
    .load_rd   (b_rd),
    .load_data (b_data),
    .valid     (b_full),
    .rd        (b_slot_rd),
    .data      (b_slot_data)
  );

  // On a tie the port opposite to the last winner is served.
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (!hold) begin
      if (a_full && b_full) begin
        if (last == PORT_B) grant_a_c = 1'b1;
        else                grant_b_c = 1'b1;
      end else begin
        grant_a_c = a_full;
        grant_b_c = b_full;
      end
    end
  end

  assign grant_c    = grant_a_c | grant_b_c;
  assign sel_rd_c   = grant_b_c ? b_slot_rd   : a_slot_rd;
  assign sel_data_c = grant_b_c ? b_slot_data : a_slot_data;

  // A slot being drained this cycle can refill at the same edge.
  assign a_ready  = !reset && (!a_full || grant_a_c);
  assign b_ready  = !reset && (!b_full || grant_b_c);
  assign a_load_c = a_valid && a_ready;
  assign b_load_c = b_valid && b_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= PORT_B;
      C    <= '0;
      PW   <= '0;
      RF   <= 1'b0;
    end else begin
      RF <= 1'b0;
      if (grant_c) begin
        C    <= sel_rd_c;
        PW   <= sel_data_c;
        RF   <= (sel_rd_c != ADDR_W'(G0_ADDR));
        last <= grant_b_c ? PORT_B : PORT_A;
      end
    end
  end

  assign busy = a_full | b_full | RF;

endmodule
